button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Avalon-MM slave that replaces the bare per-button PIO ports with one controller for the panel push-buttons (up, down, etc.). It synchronizes and debounces every button, captures press events into sticky write-1-to-clear bits and raises a maskable interrupt to the Nios II. Software reads one register instead of polling raw, bouncing inputs.

## Interface
Parameters:
- N_BUTTONS, 4, number of button inputs (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz); minimum 2
- ACTIVE_LOW, 1, 1 = pressed when in_port bit is 0 (DE-board KEYs)
- REPEAT_DELAY, 25000000, cycles held before first auto-repeat (used only with BTN_AUTOREPEAT_EN)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeats (used only with BTN_AUTOREPEAT_EN)

Ports:
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register word offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  N_BUTTONS  raw asynchronous button pins
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active high

## Operation
- Register map: 0 = STATE (RO, debounced pressed levels, 1 = pressed); 1 = MASK (RW, interrupt enable per button); 2 = EVENT (sticky press flags, write 1 to clear, write 0 no effect); 3 = reads 0, writes ignored.
- Unused upper bits (>= N_BUTTONS) read 0.
- Per button: 2-flop synchronizer, then debounce FSM with states RELEASED and PRESSED plus counter.
  - Counter increments while the synchronized pressed level differs from the FSM state.
  - Any cycle where they match clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, the FSM changes state and the counter clears.
- RELEASED->PRESSED sets the EVENT bit. PRESSED->RELEASED sets nothing.
- irq = OR over (EVENT & MASK); it is combinational from registered state.
- Writes take effect when chipselect=1 and write_n=0. There are no wait states.
- readdata <= mux(address) on every clk edge, regardless of chipselect.
- Simultaneous event-set and write-1-clear on the same bit: set wins, bit stays 1.
- MASK write and new event in the same cycle: irq reflects the new MASK from the next cycle.
- Reset values: readdata 0, irq 0, MASK 0, EVENT 0, all FSMs RELEASED, counters and synchronizers 0 (pressed-level sense, i.e. released).
- Reset mid-debounce discards the partial count. A button still held after reset re-qualifies as a fresh press.

## Timing
- Numbering: edge 0 is the first clk edge sampling a new stable in_port level.
- STATE and EVENT update at edge DEBOUNCE_CYCLES+1. irq rises the same edge if MASK is set.
- Read latency: address presented before edge n gives readdata valid after edge n (one cycle).
- Write-1-clear: EVENT bit reads 0 and irq drops after the write edge.
- A glitch shorter than DEBOUNCE_CYCLES causes no state change and no event.

## Configuration
- Macro: BTN_AUTOREPEAT_EN.
- When defined:
  - Each button carries a hold counter.
  - While PRESSED, EVENT is set again after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - Release clears the hold counter.
  - Repeat sets follow the set-wins rule.
- When undefined: no hold counters are synthesized, and exactly one event is generated per press.

## Structure
- Package btn_ctrl_pkg holds:
  - register offsets (ADDR_STATE=0, ADDR_MASK=1, ADDR_EVENT=2)
  - debounce state enum {RELEASED, PRESSED}
  - a function for counter width: clog2 of max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
- Sub-module btn_debounce contains synchronizer, FSM, counter and optional repeat logic. It outputs level and a 1-cycle press pulse, and is instantiated N_BUTTONS times in a generate loop.
- The top level holds the register file, readdata mux and irq.

## Test plan
- Reset release with all in_port=1 (ACTIVE_LOW) -> STATE=0, EVENT=0, irq=0, readdata=0.
- Bench with DEBOUNCE_CYCLES=8: write MASK=0x1, hold in_port[0]=0 -> EVENT=0x1 and irq=1 exactly at edge 9. Write EVENT=0x1 -> irq=0 and EVENT reads 0.
- 5-cycle low glitch on in_port[1] -> STATE and EVENT unchanged, irq stays 0.
- New press on bit 2 coinciding with a write EVENT=0x4 -> EVENT bit 2 reads 1.
- Assert reset_n mid-count, then keep button held -> no event until a full DEBOUNCE_CYCLES after release of reset.
- With BTN_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10, holding and clearing after each event -> events at press, +20, +30, +40 cycles. Without the macro -> a single event.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg
// Shared definitions for the push-button event controller:
//   - Avalon register word offsets
//   - debounce FSM state encoding
//   - counter width helper sized for the largest count any counter needs
package btn_ctrl_pkg;

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EVENT = 2'd2;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } db_state_t;

    // Width able to hold 0 .. max(a,b,c)-1; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One push-button channel: 2-flop synchronizer, RELEASED/PRESSED debounce FSM
// with a stability counter and, when BTN_AUTOREPEAT_EN is defined, a hold
// counter that re-fires the press pulse while the button stays pressed.
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   btn_raw     raw asynchronous button pin
//   level       debounced pressed level (1 = pressed)
//   press_pulse 1-cycle pulse, combinational, asserted in the cycle before the
//               edge that moves the FSM to PRESSED (and before each repeat edge)
// Optional feature macro: BTN_AUTOREPEAT_EN
module btn_debounce
    import btn_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronize in pressed-level sense so that reset (all zeros) means released.
    logic       btn_pressed_raw;
    logic [1:0] sync_reg;
    logic       sync_level;

    assign btn_pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    assign sync_level      = sync_reg[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_pressed_raw};
        end
    end

    db_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             edge_press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        edge_press = 1'b0;
        if (sync_level == (state_reg == PRESSED)) begin
            cnt_next = '0;
        end else if (cnt_reg == DB_LAST) begin
            // Input has differed for DEBOUNCE_CYCLES consecutive cycles.
            cnt_next = '0;
            if (state_reg == RELEASED) begin
                state_next = PRESSED;
                edge_press = 1'b1;
            end else begin
                state_next = RELEASED;
            end
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign level = (state_reg == PRESSED);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // armed_reg: first (REPEAT_DELAY) repeat already fired, now on REPEAT_PERIOD.
    logic [CNT_W-1:0] hold_reg, hold_next;
    logic             armed_reg, armed_next;
    logic             rep_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg  <= '0;
            armed_reg <= 1'b0;
        end else begin
            hold_reg  <= hold_next;
            armed_reg <= armed_next;
        end
    end

    always_comb begin
        hold_next  = hold_reg;
        armed_next = armed_reg;
        rep_pulse  = 1'b0;
        if (state_reg != PRESSED || state_next != PRESSED) begin
            // Not held (or being released this cycle): restart timing.
            hold_next  = '0;
            armed_next = 1'b0;
        end else if (!armed_reg && hold_reg == RD_LAST) begin
            hold_next  = '0;
            armed_next = 1'b1;
            rep_pulse  = 1'b1;
        end else if (armed_reg && hold_reg == RP_LAST) begin
            hold_next  = '0;
            rep_pulse  = 1'b1;
        end else begin
            hold_next  = hold_reg + 1'b1;
        end
    end

    assign press_pulse = edge_press | rep_pulse;
`else
    assign press_pulse = edge_press;
`endif

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl
// Avalon-MM slave collecting debounced push-button presses into sticky
// write-1-to-clear event flags with a maskable level interrupt.
// Registers (word offset): 0 STATE (RO), 1 MASK (RW), 2 EVENT (W1C), 3 reads 0.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata                      Avalon-MM slave write/select side
//   readdata                       registered read data (1-cycle latency)
//   in_port[N_BUTTONS]             raw button pins
//   irq                            OR of (EVENT & MASK)
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat events while held)
module button_event_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    input  logic [N_BUTTONS-1:0] in_port,
    output logic [31:0]          readdata,
    output logic                 irq
);

    logic [N_BUTTONS-1:0] level_vec;
    logic [N_BUTTONS-1:0] press_vec;

    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_db (
                .clk         (clk),
                .reset_n     (reset_n),
                .btn_raw     (in_port[gi]),
                .level       (level_vec[gi]),
                .press_pulse (press_vec[gi])
            );
        end
    endgenerate

    logic [N_BUTTONS-1:0] mask_reg, mask_next;
    logic [N_BUTTONS-1:0] event_reg, event_next;
    logic [31:0]          readdata_reg, readdata_next;
    logic                 wr_en;
    logic                 unused_wdata;

    // Bits of writedata above N_BUTTONS carry no register state.
    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    always_comb begin
        mask_next  = mask_reg;
        event_next = event_reg;
        if (wr_en && address == ADDR_MASK) begin
            mask_next = writedata[N_BUTTONS-1:0];
        end
        if (wr_en && address == ADDR_EVENT) begin
            event_next = event_reg & ~writedata[N_BUTTONS-1:0];
        end
        // Applied after the clear so a coincident new event is never lost.
        event_next = event_next | press_vec;
    end

    always_comb begin
        readdata_next = 32'd0;
        case (address)
            ADDR_STATE: readdata_next[N_BUTTONS-1:0] = level_vec;
            ADDR_MASK:  readdata_next[N_BUTTONS-1:0] = mask_reg;
            ADDR_EVENT: readdata_next[N_BUTTONS-1:0] = event_reg;
            default:    readdata_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg     <= '0;
            event_reg    <= '0;
            readdata_reg <= 32'd0;
        end else begin
            mask_reg     <= mask_next;
            event_reg    <= event_next;
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(event_reg & mask_reg);

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl
// Directed bench for button_event_ctrl with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20,
// REPEAT_PERIOD=10, four active-low buttons. Register-access vectors are
// table driven; debounce timing corners are hand-written sequences.
module tb_button_event_ctrl;

    localparam int NB = 4;
    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_MASK  = 2'd1;
    localparam logic [1:0] A_EVENT = 2'd2;
    localparam logic [1:0] A_RSVD  = 2'd3;

    logic          clk;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [NB-1:0] in_port;
    logic [31:0]   readdata;
    logic          irq;

    int n_cmp  = 0;
    int n_fail = 0;

    button_event_ctrl #(
        .N_BUTTONS       (NB),
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (10)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic w, input logic [1:0] a,
                                input logic [31:0] d, input logic [31:0] e,
                                input string n);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.data  = d;
        v.exp   = e;
        v.name  = n;
        return v;
    endfunction

    // Advance past the next rising edge; all sampling and driving happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    initial begin
        logic [31:0] rd;
        int          ev_edges[$];
        int          exp_edges[$];

        reset_n    = 1'b0;
        address    = A_STATE;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = '1;

        // ---- reset state ----
        repeat (3) tick();
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        tick();

        // ---- register access table ----
        vecs[0]  = mk(1'b0, A_STATE, 32'h0,        32'h0, "rd_state_idle");
        vecs[1]  = mk(1'b0, A_EVENT, 32'h0,        32'h0, "rd_event_idle");
        vecs[2]  = mk(1'b0, A_MASK,  32'h0,        32'h0, "rd_mask_reset");
        vecs[3]  = mk(1'b1, A_MASK,  32'hF,        32'h0, "wr_mask_f");
        vecs[4]  = mk(1'b0, A_MASK,  32'h0,        32'hF, "rd_mask_f");
        vecs[5]  = mk(1'b1, A_MASK,  32'hFFFFFFFF, 32'h0, "wr_mask_all");
        vecs[6]  = mk(1'b0, A_MASK,  32'h0,        32'hF, "rd_mask_upper0");
        vecs[7]  = mk(1'b1, A_RSVD,  32'hFFFFFFFF, 32'h0, "wr_rsvd");
        vecs[8]  = mk(1'b0, A_RSVD,  32'h0,        32'h0, "rd_rsvd");
        vecs[9]  = mk(1'b1, A_MASK,  32'h5,        32'h0, "wr_mask_5");
        vecs[10] = mk(1'b0, A_MASK,  32'h0,        32'h5, "rd_mask_5");
        vecs[11] = mk(1'b1, A_EVENT, 32'hF,        32'h0, "wr_event_clr");
        vecs[12] = mk(1'b0, A_EVENT, 32'h0,        32'h0, "rd_event_clr");
        vecs[13] = mk(1'b1, A_MASK,  32'h0,        32'h0, "wr_mask_0");
        vecs[14] = mk(1'b0, A_MASK,  32'h0,        32'h0, "rd_mask_0");

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr) begin
                bus_wr(vecs[i].addr, vecs[i].data);
                $display("vec %0d %s write addr=%0d data=0x%08h", i, vecs[i].name,
                         vecs[i].addr, vecs[i].data);
            end else begin
                bus_rd(vecs[i].addr, rd);
                $display("vec %0d %s read addr=%0d data=0x%08h", i, vecs[i].name,
                         vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end
        check("tbl_irq", {31'd0, irq}, 32'd0);

        // ---- press button 0: event and irq exactly at edge 9 ----
        bus_wr(A_MASK, 32'h1);
        in_port[0] = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check($sformatf("p0_irq_edge%0d", e), {31'd0, irq}, (e == 9) ? 32'd1 : 32'd0);
        end
        bus_rd(A_EVENT, rd);
        check("p0_event", rd, 32'h1);
        bus_wr(A_EVENT, 32'h1);
        check("p0_irq_after_clr", {31'd0, irq}, 32'd0);
        bus_rd(A_EVENT, rd);
        check("p0_event_after_clr", rd, 32'h0);
        bus_rd(A_STATE, rd);
        check("p0_state_held", rd, 32'h1);
        in_port[0] = 1'b1;
        repeat (12) tick();
        bus_rd(A_STATE, rd);
        check("p0_state_released", rd, 32'h0);
        bus_rd(A_EVENT, rd);
        check("p0_no_release_event", rd, 32'h0);
        $display("seq press0 done");

        // ---- 5-cycle glitch on button 1 ----
        bus_wr(A_MASK, 32'hF);
        in_port[1] = 1'b0;
        repeat (5) tick();
        in_port[1] = 1'b1;
        repeat (15) tick();
        check("glitch_irq", {31'd0, irq}, 32'd0);
        bus_rd(A_STATE, rd);
        check("glitch_state", rd, 32'h0);
        bus_rd(A_EVENT, rd);
        check("glitch_event", rd, 32'h0);
        $display("seq glitch done");

        // ---- press on button 2 coinciding with write-1-clear of bit 2 ----
        in_port[2] = 1'b0;
        repeat (9) tick();           // edges 0..8
        bus_wr(A_EVENT, 32'h4);      // edge 9: set and clear together
        check("setwins_irq", {31'd0, irq}, 32'd1);
        bus_rd(A_EVENT, rd);
        check("setwins_event", rd, 32'h4);
        bus_wr(A_EVENT, 32'h4);
        bus_rd(A_EVENT, rd);
        check("setwins_cleared", rd, 32'h0);
        in_port[2] = 1'b1;
        repeat (12) tick();
        $display("seq set_wins done");

        // ---- reset mid-count on button 3, button kept held ----
        in_port[3] = 1'b0;
        repeat (6) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        check("midrst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        bus_wr(A_MASK, 32'h8);       // edge 0 after reset release
        check("midrst_irq_edge0", {31'd0, irq}, 32'd0);
        for (int e = 1; e <= 9; e++) begin
            tick();
            check($sformatf("midrst_irq_edge%0d", e), {31'd0, irq}, (e == 9) ? 32'd1 : 32'd0);
        end
        bus_wr(A_EVENT, 32'h8);
        in_port[3] = 1'b1;
        repeat (12) tick();
        check("midrst_irq_cleared", {31'd0, irq}, 32'd0);
        $display("seq reset_mid_count done");

        // ---- long hold on button 0, clearing after every event ----
        bus_wr(A_MASK, 32'h1);
        in_port[0] = 1'b0;
        for (int e = 0; e < 56; e++) begin
            tick();
            if (chipselect) begin
                chipselect = 1'b0;
                write_n    = 1'b1;
            end
            if (irq) begin
                ev_edges.push_back(e);
                address    = A_EVENT;
                writedata  = 32'h1;
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
        end
        if (chipselect) begin
            tick();
            chipselect = 1'b0;
            write_n    = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        exp_edges = '{9, 29, 39, 49};
`else
        exp_edges = '{9};
`endif
        check("hold_event_count", ev_edges.size(), exp_edges.size());
        for (int i = 0; i < exp_edges.size(); i++) begin
            if (i < ev_edges.size()) begin
                check($sformatf("hold_event%0d_edge", i), ev_edges[i], exp_edges[i]);
            end
        end
        in_port[0] = 1'b1;
        repeat (12) tick();
        bus_wr(A_EVENT, 32'hF);
        check("final_irq", {31'd0, irq}, 32'd0);
        $display("seq hold done events=%0d", ev_edges.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
